// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter granting one of four requesters access to a shared
// decoder-driven resource, with a bounded hold time and a mandatory dead cycle.
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  input  logic       enable,
  output logic [1:0] grant_idx,
  output logic [3:0] grant_oh,
  output logic       grant_valid,
  output logic       timeout,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_next;
  logic [1:0] ptr, ptr_next;
  logic [1:0] idx_next;
  logic [7:0] hold_cnt, hold_next;
  logic       timeout_next;
  logic       found;
  logic [1:0] pick;
  logic [1:0] cand;

  // Rotating priority scan: first requester at or after ptr wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    found = 1'b0;
    pick  = ptr;
    cand  = ptr;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    idx_next     = grant_idx;
    hold_next    = hold_cnt;
    timeout_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && found) begin
          state_next = GRANT;
          idx_next   = pick;
          ptr_next   = pick + 2'd1;
          hold_next  = 8'd0;
        end
      end
      GRANT: begin
        // A completion or a withdrawal wins over the hold limit: no timeout pulse.
        if (done || !req[grant_idx]) begin
          state_next = RELEASE;
        end else if (hold_cnt == HOLD_LAST) begin
          state_next   = RELEASE;
          timeout_next = 1'b1;
        end else begin
          hold_next = hold_cnt + 8'd1;
        end
      end
      RELEASE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      hold_cnt    <= 8'd0;
      grant_idx   <= 2'd0;
      grant_oh    <= 4'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      hold_cnt    <= hold_next;
      grant_idx   <= idx_next;
      grant_oh    <= (state_next == GRANT) ? (4'b0001 << idx_next) : 4'd0;
      grant_valid <= (state_next == GRANT);
      timeout     <= timeout_next;
      busy        <= (state_next != IDLE);
    end
  end

endmodule
